// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a little-endian byte stream made of a
// 32-bit word count followed by that many words. Each word is written to
// instruction memory with a one-cycle we strobe, and a running checksum of
// the written words is kept.
module imem_loader #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       csum
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;

   // Largest legal word count; counts are compared in 33 bits so 2^32-1 cannot alias
   localparam logic [32:0]     DEPTH = 33'(1) << ADDR_W;
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   state_t          state;
   logic [1:0]      bcnt;     // byte position within the current 4-byte group
   logic [31:0]     shreg;    // assembly buffer, kept apart from wdata so wdata holds
   logic [ADDR_W:0] idx;      // one bit wider so idx can reach a count of 2^ADDR_W
   logic [ADDR_W:0] nwords;

   logic        xfer;
   logic [31:0] word_nxt;
   logic [ADDR_W:0] idx_inc;

   assign xfer     = in_valid && in_ready;
   // Bytes enter at the top, so after four shifts the first byte sits in [7:0]
   assign word_nxt = {in_data, shreg[31:8]};
   assign idx_inc  = idx + ONE;

   // Loader FSM; every output is a register updated alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         bcnt     <= '0;
         shreg    <= '0;
         idx      <= '0;
         nwords   <= '0;
         in_ready <= 1'b0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         csum     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN;
                  bcnt     <= '0;
                  idx      <= '0;
                  csum     <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  shreg <= word_nxt;
                  bcnt  <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     if (word_nxt == 32'd0) begin
                        state    <= S_DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                     end else if ({1'b0, word_nxt} > DEPTH) begin
                        state    <= S_ERR;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                     end else begin
                        state  <= S_DATA;
                        nwords <= word_nxt[ADDR_W:0];
                     end
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  shreg <= word_nxt;
                  bcnt  <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     state    <= S_WRITE;
                     in_ready <= 1'b0;
                     we       <= 1'b1;
                     waddr    <= idx[ADDR_W-1:0];
                     wdata    <= word_nxt;
                  end
               end
            end
            S_WRITE: begin
               we   <= 1'b0;
               csum <= csum + wdata;
               idx  <= idx_inc;
               if (idx_inc == nwords) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state    <= S_DATA;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               we       <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, giving the instruction-memory word-address width (depth 2^ADDR_W = 16384 words).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  begin a load; sampled only in IDLE, DONE or ERR.
REQ-005 SHALL have port in_data  input  8  incoming program byte.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte; a byte transfers on a rising edge with in_valid&&in_ready.
REQ-008 SHALL have port we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port waddr  output  ADDR_W  word address for the write (byte address = waddr<<2).
REQ-010 SHALL have port wdata  output  32  assembled instruction word.
REQ-011 SHALL have port busy  output  1  load in progress; the core is held stalled while high.
REQ-012 SHALL have port done  output  1  sticky: last load completed.
REQ-013 SHALL have port err  output  1  sticky: header length exceeded memory depth.
REQ-014 SHALL have port csum  output  32  modulo-2^32 sum of all words written in the current load.

Function
REQ-015 SHALL implement the states IDLE, LEN, DATA, WRITE, DONE and ERR.
REQ-016 Stream format SHALL be a 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte goes to wdata[7:0]).
REQ-017 In IDLE, DONE or ERR, start=1 SHALL move to LEN and clear the byte counter, word index, csum, done and err.
REQ-018 start SHALL be ignored in LEN, DATA and WRITE.
REQ-019 in_ready SHALL be 1 only in LEN and DATA; a byte offered in any other state SHALL NOT be consumed.
REQ-020 In LEN, after the 4th accepted byte: N==0 SHALL go to DONE; N>2^ADDR_W SHALL go to ERR; otherwise SHALL go to DATA.
REQ-021 In DATA, after the 4th accepted byte of a word, SHALL go to WRITE.
REQ-022 In WRITE, SHALL assert we for exactly one cycle with waddr=word index and wdata=the assembled word.
REQ-023 In WRITE, on the same edge, SHALL add wdata to csum and increment the word index.
REQ-024 From WRITE, SHALL go to DONE if the incremented index equals N, else return to DATA.
REQ-025 Latency: we SHALL be high in the cycle immediately after the edge on which the 4th byte of a word transferred.
REQ-026 Sustained throughput SHALL be 4 bytes per 5 cycles with in_valid held high.
REQ-027 in_valid gaps SHALL stall assembly without losing partial-word bytes.
REQ-028 The word index SHALL start at 0, so the first word lands at waddr 0.
REQ-029 N == 2^ADDR_W SHALL be legal; the last word SHALL be written at waddr 2^ADDR_W-1 with no index wrap.
REQ-030 busy SHALL be 1 exactly in LEN, DATA and WRITE.
REQ-031 done SHALL be 1 exactly in DONE, and err SHALL be 1 exactly in ERR.
REQ-032 waddr and wdata SHALL hold their last values when we=0; memory sees only the we strobe.
REQ-033 csum SHALL hold its final value in DONE and ERR until the next start.

Reset
REQ-034 On rst_n=0, at any time and including mid-word, SHALL enter IDLE asynchronously.
REQ-035 While rst_n=0, SHALL drive in_ready=0, we=0, busy=0, done=0, err=0, waddr=0, wdata=0 and csum=0.
REQ-036 A partial word SHALL be discarded on reset and SHALL NOT be written.
REQ-037 After rst_n deasserts, SHALL stay in IDLE until start.

Verification
REQ-038 Bench SHALL cover: start; bytes 02 00 00 00, 13 00 00 00, EF 00 40 07 -> we at waddr 0 with 0x00000013, then waddr 1 with 0x074000EF; done=1; csum=0x07400102.
REQ-039 Bench SHALL cover: header 00 00 00 00 -> DONE with no we pulse; csum=0.
REQ-040 Bench SHALL cover: header 01 40 00 00 (N=16385) -> err=1, in_ready=0, no we pulse; then start clears err.
REQ-041 Bench SHALL cover: N=1 with in_valid toggling every other cycle -> single correct write; no byte duplicated or dropped.
REQ-042 Bench SHALL cover: rst_n pulsed low after 2 data bytes -> no we pulse, all outputs at reset values; a fresh load then writes from waddr 0.
REQ-043 Bench SHALL cover: start pulsed during DATA -> ignored, and the load completes normally.
